pipe_ctrl_chain: RTL
====================

Name: pipe_ctrl_chain

Overview:
Parametrised elastic pipeline register chain for control words, such as the EX/MEM/WB control-signal bundles. It generalises the fixed ID->EX->MEM->WB control registers to DEPTH stages of WIDTH bits. Each stage has a per-stage valid bit, valid/ready backpressure, a global stall and per-stage flush. It sits between the control unit (producer) and the write-back consumer and exposes every stage for the debug monitor.

Parameters:
WIDTH, 10, bits per control word
DEPTH, 3, number of register stages (>=1); stage 0 is youngest, stage DEPTH-1 drives the output
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  producer has a word
in_ready  out  1  chain accepts a word this cycle
in_data  in  WIDTH  incoming control word
out_valid  out  1  stage DEPTH-1 holds a valid word
out_ready  in  1  consumer accepts the output word
out_data  out  WIDTH  data of stage DEPTH-1
stall  in  1  freeze the whole chain
flush_mask  in  DEPTH  bit i invalidates stage i at the next edge
stage_valid  out  DEPTH  valid bit per stage
stage_data  out  DEPTH*WIDTH  data per stage; stage i at [i*WIDTH +: WIDTH]
occupancy  out  CNT_W  number of valid stages

Behaviour:
- Reset (Reset=0, async): all valid=0, all data=0, occupancy=0, out_valid=0, out_data=0. Reset asserted mid-transfer discards all contents. The first edge after release behaves as a normal cycle.
- Ready chain (combinational): rdy[DEPTH] = out_ready & ~stall; rdy[i] = ~valid[i] | rdy[i+1]. Then in_ready = rdy[0] & ~stall.
- Transfers:
  - Stage i loads from stage i-1 (stage 0 loads from in_data/in_valid) when rdy[i] is 1 and stall is 0.
  - A stage that has been emptied to the next stage and receives nothing goes invalid.
  - Output handshake is out_valid & out_ready & ~stall.
- Stall=1: no register changes except flush. in_ready=0. out_valid still reflects valid[DEPTH-1], but no output handshake occurs.
- Flush: at the edge, next valid[i] = flush_mask[i] ? 0 : computed value.
  - Flush beats stall and load.
  - A word moving into a flushed stage is lost. A word leaving a flushed stage in the same cycle completes its move.
  - flush_mask[0] together with an input handshake drops the incoming word; in_ready is still reported normally.
- Latency: an accepted word appears on out_valid DEPTH cycles after the accept edge when there is no stall or backpressure. Throughput is 1 word/cycle. A full chain with out_ready=1 accepts and emits in the same cycle.
- Full: all valid and out_ready=0 -> in_ready=0; data is held.
- Empty: out_valid=0. out_data retains the last value unless PIPE_BUBBLE_ZERO_EN is defined.
- occupancy: registered popcount of next valid bits; range 0..DEPTH with no wrap.
- Data registers load only on a transfer (clock-enable style).

Optional Feature:
PIPE_BUBBLE_ZERO_EN:
- Defined: a stage's data register is cleared to 0 at any edge where its next valid is 0 (flush, drain, or reset). stage_data and out_data of invalid stages therefore read 0, so bubbles carry all-zero (NOP) control signals.
- Undefined: invalid stages keep stale data, and consumers must qualify data with valid.

Decomposition:
- Shared package pipe_pkg: default WIDTH/DEPTH constants and a NOP control-word constant (all zeros).
- One sub-module, pipe_stage_reg: a single elastic stage with valid, data, load, flush and ready-in/ready-out. It is generated DEPTH times.
- Top-level pipe_ctrl_chain: ready-chain wiring and the occupancy counter.

Test Plan:
- Stream, DEPTH=3, WIDTH=10: in_data 0x001,0x002,0x003 on consecutive cycles with out_ready=1 -> 0x001 on out_data with out_valid at the 3rd edge after its accept, followed by 0x002 and 0x003 back-to-back; occupancy peaks at 3.
- Backpressure: fill 3 words with out_ready=0 -> in_ready=0 and occupancy=3. Raise out_ready for 1 cycle -> exactly one word exits and in_ready returns to 1 in the same cycle.
- Stall: chain holding 0x0A5@s0 and 0x15A@s1, stall=1 for 4 cycles with in_valid=1 -> stage_data/valid unchanged and no accept. Stall released -> movement resumes on the next edge.
- Flush: flush_mask=3'b011 while s0=0x011, s1=0x022, s2=0x033 -> next stage_valid=3'b100 (s2 holds 0x022 moved from s1), occupancy=1, and 0x033 exits if out_ready=1. With PIPE_BUBBLE_ZERO_EN, s0/s1 data read 0x000.
- Async reset mid-stream: drive Reset=0 between clock edges with 2 valid words -> outputs clear immediately (no edge needed), occupancy=0. After release, in_data 0x3FF emerges after 3 edges.
- DEPTH=1 and DEPTH=5 builds: repeat the stream test -> latency equals DEPTH and occupancy saturates at DEPTH.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the control-word pipeline chain.
//   PIPE_WIDTH   : default control-word width
//   PIPE_DEPTH   : default number of register stages
//   PIPE_NOP_BIT : fill value of one bit of a NOP control word
//   PIPE_NOP     : all-zero NOP control word at the default width
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 10;
  localparam int unsigned PIPE_DEPTH = 3;

  localparam logic                  PIPE_NOP_BIT = 1'b0;
  localparam logic [PIPE_WIDTH-1:0] PIPE_NOP     = {PIPE_WIDTH{PIPE_NOP_BIT}};

endpackage

// File: rtl/pipe_stage_reg.sv
// One elastic stage of the control-word chain: valid bit plus data register.
// Optional build macro: PIPE_BUBBLE_ZERO_EN (clear data whenever the stage goes invalid).
// Ports:
//   Clk, Reset    : clock (rising edge), asynchronous active-low reset
//   stall_i       : freeze the stage (flush still applies)
//   flush_i       : invalidate the stage at the next edge
//   rdy_i         : downstream stage (or consumer) can take this stage's word
//   src_valid_i   : upstream word valid
//   src_data_i    : upstream word
//   valid_o       : stage valid
//   data_o        : stage data
//   valid_next_o  : valid value to be registered at the next edge
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             rdy_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_next_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // The stage takes a new (possibly empty) word when it is empty or its word moves on.
  assign load = (~valid_q | rdy_i) & ~stall_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = src_valid_i;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
    // Clock-enable style: data only changes when a real word arrives.
    if (load && src_valid_i && !flush_i) begin
      data_d = src_data_i;
    end
`ifdef PIPE_BUBBLE_ZERO_EN
    if (!valid_d) begin
      data_d = {WIDTH{PIPE_NOP_BIT}};
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{PIPE_NOP_BIT}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign valid_next_o = valid_d;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Elastic register chain for control words (e.g. EX/MEM/WB control bundles).
// DEPTH stages of WIDTH bits with valid/ready backpressure, global stall and per-stage flush.
// Optional build macro: PIPE_BUBBLE_ZERO_EN (invalid stages read all-zero NOP data).
// Ports:
//   Clk, Reset           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : producer handshake, in_data is the incoming word
//   out_valid/out_ready  : consumer handshake, out_data is stage DEPTH-1
//   stall                : freeze the whole chain
//   flush_mask           : bit i invalidates stage i at the next edge
//   stage_valid          : per-stage valid bits
//   stage_data           : per-stage data, stage i at [i*WIDTH +: WIDTH]
//   occupancy            : registered count of valid stages
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH,
  parameter int unsigned DEPTH = PIPE_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   stall,
  input  logic [DEPTH-1:0]       flush_mask,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNT_W-1:0]       occupancy
);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] valid_next;
  logic [WIDTH-1:0] data_w [DEPTH];
  logic [CNT_W-1:0] occ_q, occ_d;

  // rdy[i] = ~valid[i] | rdy[i+1] unrolled: each bit is built straight from the valid
  // bits so no vector feeds back on itself.
  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      logic r;
      r = out_ready & ~stall;
      for (int j = i; j < DEPTH; j++) begin
        r = r | ~stage_valid[j];
      end
      rdy[i] = r;
    end
  end

  assign in_ready = rdy[0] & ~stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stage_valid[i-1];
      assign src_data  = data_w[i-1];
    end

    pipe_stage_reg #(
      .WIDTH(WIDTH)
    ) u_stage (
      .Clk         (Clk),
      .Reset       (Reset),
      .stall_i     (stall),
      .flush_i     (flush_mask[i]),
      .rdy_i       (rdy[i+1]),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .valid_o     (stage_valid[i]),
      .data_o      (data_w[i]),
      .valid_next_o(valid_next[i])
    );

    assign stage_data[i*WIDTH +: WIDTH] = data_w[i];
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = data_w[DEPTH-1];

  // Popcount of the next valid bits so occupancy tracks stage_valid cycle for cycle.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNT_W'(valid_next[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
